// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared constants for the bit-serial subtraction controller
package sub_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_e;

    // Legal operand width range for serial_sub_ctrl
    localparam int SUB_WIDTH_MIN = 2;
    localparam int SUB_WIDTH_MAX = 32;

    // Bit-counter width; callers stay inside the legal range so this is >= 1
    function automatic int sub_cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_sub_insta.sv
// rtl/full_sub_insta.sv - one-bit full-subtractor cell: D = A - B - C, BO = borrow out
module full_sub_insta (
    output logic D,
    output logic BO,
    input  logic A,
    input  logic B,
    input  logic C
);

    // Difference bit and borrow out of a single-bit subtraction
    always_comb begin
        D  = A ^ B ^ C;
        BO = (~A & B) | (~A & C) | (B & C);
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial A - B - bin controller around one full-subtractor cell
module serial_sub_ctrl
    import sub_pkg::*;
#(
    // Operand/result width, must lie in SUB_WIDTH_MIN..SUB_WIDTH_MAX
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int                CNT_W    = sub_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;

    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             borrow_q, borrow_d;
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic             bout_q,   bout_d;
    logic             ovf_q,    ovf_d;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] res_shifted;
    logic             last_bit;

    // The single arithmetic element: current LSBs plus the fed-back borrow
    full_sub_insta u_cell (
        .D  (cell_d),
        .BO (cell_bo),
        .A  (a_sh_q[0]),
        .B  (b_sh_q[0]),
        .C  (borrow_q)
    );

    // Result register with the new difference bit entering at the MSB; after
    // WIDTH shifts the oldest (LSB) difference bit sits at bit 0
    assign res_shifted = WIDTH'({cell_d, res_sh_q} >> 1);
    assign last_bit    = (cnt_q == CNT_LAST);

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE waits for start, RUN spends one edge per bit, DONE lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded directly from the state
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_IDLE: ready = 1'b1;
            ST_RUN:  busy  = 1'b1;
            ST_DONE: done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Datapath next-state: capture on accept, shift one bit per RUN edge,
    // publish the result only on the final bit so diff never shows a partial value
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_shifted;
                borrow_d = cell_bo;
                if (last_bit) begin
                    // Counter parks at WIDTH-1 rather than wrapping
                    diff_d = res_shifted;
                    bout_d = cell_bo;
                    // Signed overflow: operands differ in sign and result sign differs from A
                    ovf_d  = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                a_sh_d = a_sh_q;
            end
        endcase
    end

    // Datapath registers; all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - self-checking bench for serial_sub_ctrl at WIDTH=8 and WIDTH=4
module tb_serial_sub_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       start8, bin8, ready8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, diff8;

    logic       start4, bin4, ready4, busy4, done4, bout4, ovf4;
    logic [3:0] a4, b4, diff4;

    int n_checks = 0;
    int n_errors = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .ready(ready4), .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical definitions
    function automatic void ref_sub(input int w, input int av, input int bv, input int bi,
                                    output int d, output int bo, output int ov);
        int m, raw, sa, sb, sr;
        m   = 1 << w;
        raw = av - bv - bi;
        d   = ((raw % m) + m) % m;
        bo  = (raw < 0) ? 1 : 0;
        sa  = (av >= m / 2) ? av - m : av;
        sb  = (bv >= m / 2) ? bv - m : bv;
        sr  = sa - sb - bi;
        ov  = (sr < -(m / 2) || sr > (m / 2 - 1)) ? 1 : 0;
    endfunction

    function automatic logic [31:0] outs8();
        return 32'({ready8, busy8, done8, diff8, bout8, ovf8});
    endfunction

    localparam logic [31:0] RESET_OUTS8 = 32'({1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});

    // One operation on the WIDTH=8 instance; returns results, latency, busy cycles, ready afterwards
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                           output logic [7:0] d, output logic bo, output logic ov,
                           output int lat, output int nbusy, output logic rdy);
        @(negedge clk);
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        lat = -1; nbusy = 0; d = '0; bo = 1'b0; ov = 1'b0;
        for (int n = 1; n <= 30 && lat < 0; n++) begin
            @(negedge clk);
            if (busy8) nbusy++;
            if (done8) begin
                lat = n; d = diff8; bo = bout8; ov = ovf8;
            end
        end
        @(negedge clk);
        rdy = ready8;
    endtask

    task automatic do_op8(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                          input int ed, input int eb, input int eo);
        logic [7:0] d;
        logic       bo, ov, rdy;
        int         lat, nbusy;
        run_op8(av, bv, bi, d, bo, ov, lat, nbusy, rdy);
        check_eq({tag, "_latency"}, 32'(lat), 32'd9);
        check_eq({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
        check_eq({tag, "_diff"}, 32'(d), 32'(ed));
        check_eq({tag, "_bout"}, 32'(bo), 32'(eb));
        check_eq({tag, "_ovf"}, 32'(ov), 32'(eo));
        check_eq({tag, "_ready_after"}, 32'(rdy), 32'd1);
    endtask

    initial begin
        int ed, eb, eo, ndone, idx, got_cnt, last_done, cyc, e;
        logic [7:0] cap_diff;
        logic [7:0] ra, rb;
        logic       rbi;
        int exp_q[$];

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_outs8", outs8(), RESET_OUTS8);
        check_eq("reset_outs4", 32'({ready4, busy4, done4, diff4, bout4, ovf4}),
                 32'({1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0}));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("idle_hold", outs8(), RESET_OUTS8);
        end

        // Directed cases from the plan
        do_op8("basic",      8'h5A, 8'h27, 1'b0, 'h33, 0, 0);
        do_op8("borrow",     8'h00, 8'h01, 1'b1, 'hFE, 1, 0);
        do_op8("signed_ovf", 8'h80, 8'h01, 1'b0, 'h7F, 0, 1);
        do_op8("equal",      8'hC3, 8'hC3, 1'b0, 'h00, 0, 0);
        do_op8("max_minus",  8'hFF, 8'h00, 1'b1, 'hFE, 0, 0);
        do_op8("pos_ovf",    8'h7F, 8'hFF, 1'b1, 'h7F, 1, 0);

        // Start while busy is ignored
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        ndone = 0; cap_diff = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 3) begin
                a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
            end
            if (n == 4) start8 = 1'b0;
            if (done8) begin
                ndone++; cap_diff = diff8;
            end
        end
        check_eq("busy_ignore_diff", 32'(cap_diff), 32'h0F);
        check_eq("busy_ignore_dones", 32'(ndone), 32'd1);

        // Reset mid-operation
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midreset_outs", outs8(), RESET_OUTS8);
        rst = 1'b0;
        ndone = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check_eq("midreset_no_done", 32'(ndone), 32'd0);
        do_op8("after_reset", 8'h03, 8'h05, 1'b0, 'hFE, 1, 0);

        // Random operations against the reference model
        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
            ref_sub(8, int'(ra), int'(rb), int'(rbi), ed, eb, eo);
            do_op8("random", ra, rb, rbi, ed, eb, eo);
        end

        // Exhaustive WIDTH=4 sweep with start held high
        idx = 0; got_cnt = 0; last_done = -1; cyc = 0;
        @(negedge clk);
        while (got_cnt < 512 && cyc < 5000) begin
            if (done4) begin
                if (exp_q.size() == 0) begin
                    check_eq("sweep_spurious_done", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sweep_diff", 32'(diff4), 32'(e & 15));
                    check_eq("sweep_bout", 32'(bout4), 32'((e >> 4) & 1));
                    check_eq("sweep_ovf", 32'(ovf4), 32'((e >> 5) & 1));
                end
                if (last_done >= 0) check_eq("sweep_spacing", 32'(cyc - last_done), 32'd6);
                last_done = cyc;
                got_cnt++;
            end
            if (ready4) begin
                if (idx < 512) begin
                    a4 = 4'(idx >> 5); b4 = 4'(idx >> 1); bin4 = 1'(idx);
                    ref_sub(4, idx >> 5, (idx >> 1) & 15, idx & 1, ed, eb, eo);
                    exp_q.push_back(ed | (eb << 4) | (eo << 5));
                    start4 = 1'b1;
                    idx++;
                end else begin
                    start4 = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start4 = 1'b0;
        check_eq("sweep_count", 32'(got_cnt), 32'd512);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
